// File: rtl/ahb_mem_slave.sv
// -----------------------------------------------------------------------------
// ahb_mem_slave
//
// AHB-Lite responder backed by a byte-addressable on-chip memory. It is the
// only slave on the bus, so its HREADY output is also the master's HREADY
// input.
//
// An address phase is taken on every rising edge where HREADY=1.
//   - A legal NONSEQ/SEQ transfer completes as OKAY after WAIT_STATES cycles
//     of HREADY=0.
//   - An illegal transfer gets the two-cycle ERROR response and never touches
//     the memory. A transfer is illegal if it is wider than the bus, is
//     misaligned, or runs past the end of the memory.
//   - IDLE, BUSY and unselected cycles complete as zero-wait OKAY.
//
// Parameters:
//   AHB_DATA_WIDTH    data bus width, 32 or 64
//   AHB_ADDRESS_WIDTH address bus width
//   MEM_BYTES         memory size in bytes, a multiple of the bus width in bytes
//   WAIT_STATES       HREADY=0 cycles before each OKAY completion (0..15)
//
// Ports:
//   HCLK    in   bus clock, rising edge
//   HRESET  in   synchronous active-high reset
//   HSEL    in   slave select, qualifies the address phase
//   HADDR   in   transfer address
//   HTRANS  in   IDLE/BUSY/NONSEQ/SEQ
//   HWRITE  in   1=write, 0=read
//   HSIZE   in   transfer size, bytes = 1<<HSIZE
//   HBURST  in   burst type, informational only
//   HWDATA  in   write data, valid in the write data phase
//   HREADY  out  transfer done / slave ready (registered)
//   HRESP   out  0=OKAY, 1=ERROR (registered)
//   HRDATA  out  read data; non-zero only in the completing cycle of a read
// -----------------------------------------------------------------------------
module ahb_mem_slave #(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int MEM_BYTES         = 1024,
  parameter int WAIT_STATES       = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HSEL,
  input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [AHB_DATA_WIDTH-1:0]    HRDATA
);

  // Bus encodings. These are identical to the team's ahb_pkg, so the file
  // needs no separate package.
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'b000,
    SIZE_HALF   = 3'b001,
    SIZE_WORD   = 3'b010,
    SIZE_DWORD  = 3'b011,
    SIZE_4WORD  = 3'b100,
    SIZE_8WORD  = 3'b101,
    SIZE_16WORD = 3'b110,
    SIZE_32WORD = 3'b111
  } size_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } burst_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } response_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } fsm_t;

  localparam int AW        = AHB_ADDRESS_WIDTH;
  localparam int AW1       = AHB_ADDRESS_WIDTH + 1;
  localparam int LANES     = AHB_DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int MEM_AW    = $clog2(MEM_BYTES);

  // A transfer is legal when it fits the bus, is naturally aligned and ends
  // inside the memory. The end address is computed one bit wider so a
  // transfer near the top of the address space cannot wrap to a small value.
  function automatic logic is_legal(input logic [AW-1:0] addr, input logic [2:0] size);
    logic [7:0]  nbytes;
    logic [AW-1:0] mask;
    logic [AW:0] end_addr;
    nbytes   = 8'd1 << size;
    mask     = AW'(nbytes) - AW'(1);
    end_addr = {1'b0, addr} + AW1'(nbytes);
    is_legal = (int'(nbytes) <= LANES) &&
               ((addr & mask) == {AW{1'b0}}) &&
               (end_addr <= AW1'(MEM_BYTES));
  endfunction

  logic [7:0] mem [MEM_BYTES];

  fsm_t          state, state_next;
  logic [3:0]    wait_cnt, wait_cnt_next;
  logic          ready, ready_next;
  response_t     resp, resp_next;
  logic          pending, pending_next;
  logic          cap_legal, cap_legal_next;
  logic          cap_write, cap_write_next;
  logic [AW-1:0] cap_addr, cap_addr_next;
  size_t         cap_size, cap_size_next;

  state_t trans;
  logic   addr_phase;
  logic   new_legal;

  assign trans      = state_t'(HTRANS);
  assign addr_phase = ready && HSEL && ((trans == TRANS_NONSEQ) || (trans == TRANS_SEQ));
  // Legality depends only on the values being captured, so it is decided once
  // at the address phase and stored with them.
  assign new_legal  = is_legal(HADDR, HSIZE);

  // The data phase of a legal transfer completes in the cycle where HREADY=1.
  logic complete;
  logic do_write;
  logic rd_active;

  assign complete  = ready && pending && cap_legal && (resp == RESP_OKAY);
  assign do_write  = complete && cap_write && !HRESET;
  assign rd_active = complete && !cap_write;

  // Byte lanes touched by the captured transfer.
  logic [LANE_BITS-1:0] lower_lane;
  logic [7:0]           cap_nbytes;
  logic [MEM_AW-1:0]    word_base;
  logic [LANES-1:0]     lane_en;

  assign lower_lane = cap_addr[LANE_BITS-1:0];
  assign cap_nbytes = 8'd1 << cap_size;
  assign word_base  = {cap_addr[MEM_AW-1:LANE_BITS], {LANE_BITS{1'b0}}};

  // Lane enables: from the lower lane up through lower + size - 1.
  always_comb begin
    lane_en = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if ((i >= int'(lower_lane)) && (i < int'(lower_lane) + int'(cap_nbytes))) begin
        lane_en[i] = 1'b1;
      end else begin
        lane_en[i] = 1'b0;
      end
    end
  end

  // FSM and address-phase registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      ready     <= 1'b1;
      resp      <= RESP_OKAY;
      pending   <= 1'b0;
      cap_legal <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= {AW{1'b0}};
      cap_size  <= SIZE_BYTE;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      ready     <= ready_next;
      resp      <= resp_next;
      pending   <= pending_next;
      cap_legal <= cap_legal_next;
      cap_write <= cap_write_next;
      cap_addr  <= cap_addr_next;
      cap_size  <= cap_size_next;
    end
  end

  // Next-state logic. Any cycle with HREADY=1 samples the next address phase,
  // whatever the state: ST_IDLE, the last cycle of ST_WAIT, or ST_ERR2. While
  // HREADY=0, the address bus is ignored and only the wait/error sequence
  // advances.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    ready_next     = ready;
    resp_next      = resp;
    pending_next   = pending;
    cap_legal_next = cap_legal;
    cap_write_next = cap_write;
    cap_addr_next  = cap_addr;
    cap_size_next  = cap_size;

    if (ready) begin
      if (addr_phase) begin
        pending_next   = 1'b1;
        cap_legal_next = new_legal;
        cap_write_next = HWRITE;
        cap_addr_next  = HADDR;
        cap_size_next  = size_t'(HSIZE);
        if (!new_legal) begin
          // No wait states before an error.
          state_next    = ST_ERR1;
          wait_cnt_next = 4'd0;
          ready_next    = 1'b0;
          resp_next     = RESP_ERROR;
        end else if (WAIT_STATES == 0) begin
          state_next    = ST_IDLE;
          wait_cnt_next = 4'd0;
          ready_next    = 1'b1;
          resp_next     = RESP_OKAY;
        end else begin
          state_next    = ST_WAIT;
          wait_cnt_next = 4'(WAIT_STATES);
          ready_next    = 1'b0;
          resp_next     = RESP_OKAY;
        end
      end else begin
        state_next    = ST_IDLE;
        pending_next  = 1'b0;
        wait_cnt_next = 4'd0;
        ready_next    = 1'b1;
        resp_next     = RESP_OKAY;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          // wait_cnt holds the HREADY=0 cycles still to go, this one included.
          // When it reaches 1, the next cycle is the HREADY=1 completion.
          if (wait_cnt <= 4'd1) begin
            wait_cnt_next = 4'd0;
            ready_next    = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt - 4'd1;
            ready_next    = 1'b0;
          end
        end
        ST_ERR1: begin
          state_next = ST_ERR2;
          ready_next = 1'b1;
          resp_next  = RESP_ERROR;
        end
        default: begin
          // A state with HREADY=0 other than ST_WAIT or ST_ERR1 cannot occur.
          // If it does, release the bus.
          state_next    = ST_IDLE;
          wait_cnt_next = 4'd0;
          ready_next    = 1'b1;
          resp_next     = RESP_OKAY;
        end
      endcase
    end
  end

  // Memory write, committed at the end of the completing cycle so the very
  // next data phase reads the new bytes. Memory contents are not reset.
  always_ff @(posedge HCLK) begin
    if (do_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem[word_base + MEM_AW'(i)] <= HWDATA[i*8 +: 8];
        end
      end
    end
  end

  // Read data straight from memory on active lanes of a completing read;
  // zero in every other lane and cycle.
  always_comb begin
    HRDATA = {AHB_DATA_WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (rd_active && lane_en[i]) begin
        HRDATA[i*8 +: 8] = mem[word_base + MEM_AW'(i)];
      end else begin
        HRDATA[i*8 +: 8] = 8'h00;
      end
    end
  end

  assign HREADY = ready;
  assign HRESP  = resp;

  // HBURST is informational and the address bits above the memory are always
  // zero for a legal transfer; neither drives any logic.
  logic unused_bits;
  assign unused_bits = ^{HBURST, cap_addr[AW-1:MEM_AW]};

endmodule
